// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared switch types, port ids and destination check
//
// Purpose: types and constants common to the switch datapath.
//   port_id_t     : 2-bit destination port field carried in pkt_byte_t[1:0]
//   pkt_byte_t    : one packet byte
//   is_valid_dest : true when the byte addresses a real output port
package switch_pkg;

   typedef logic [1:0] port_id_t;
   typedef logic [7:0] pkt_byte_t;

   localparam port_id_t PORT_NONE = 2'b00;
   localparam port_id_t PORT_1    = 2'b01;
   localparam port_id_t PORT_2    = 2'b10;
   localparam port_id_t PORT_3    = 2'b11;

   function automatic logic is_valid_dest(pkt_byte_t b);
      return b[1:0] != PORT_NONE;
   endfunction

endpackage

// File: rtl/ingress_port_queue_if.sv
// rtl/ingress_port_queue_if.sv - ingress byte stream and scheduler pop bus
//
// Purpose: groups the two handshakes of an ingress port queue.
//   in_data/in_valid/in_ready : MAC side byte stream into the queue
//   data/empty/rdreq          : show-ahead head byte and pop request from scheduler
// Modports:
//   master : the MAC + scheduler side (drives in_data, in_valid, rdreq)
//   slave  : the queue (drives in_ready, data, empty)
interface ingress_port_queue_if;
   import switch_pkg::*;

   pkt_byte_t in_data;
   logic      in_valid;
   logic      in_ready;
   pkt_byte_t data;
   logic      empty;
   logic      rdreq;

   modport master (
      output in_data, in_valid, rdreq,
      input  in_ready, data, empty
   );

   modport slave (
      input  in_data, in_valid, rdreq,
      output in_ready, data, empty
   );

endinterface

// File: rtl/ingress_queue_mem.sv
// rtl/ingress_queue_mem.sv - DEPTH x 8 byte storage, one write port, async read
//
// Purpose: queue storage; contents are intentionally not reset.
// Ports:
//   clk     : rising-edge clock for writes
//   wr_en   : write strobe
//   wr_addr : write index
//   wr_data : byte written
//   rd_addr : read index (combinational read)
//   rd_data : byte at rd_addr
module ingress_queue_mem
   import switch_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   wr_addr,
   input  pkt_byte_t                  wr_data,
   input  logic [$clog2(DEPTH)-1:0]   rd_addr,
   output pkt_byte_t                  rd_data
);

   pkt_byte_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ingress_port_queue.sv
// rtl/ingress_port_queue.sv - per-input-port show-ahead byte queue with stats
//
// Purpose: buffers bytes from the ingress MAC for the switch scheduler,
// discarding bytes whose destination field is PORT_NONE.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : slave side of ingress_port_queue_if (byte stream in, head/pop out)
//   level      : current occupancy, 0..DEPTH
//   drop_cnt   : saturating count of discarded invalid-destination bytes
//   ovf_cnt    : saturating count of cycles with in_valid high while full
//   rd_err     : sticky, set by rdreq while empty
//   clr_stats  : synchronous clear of drop_cnt, ovf_cnt and rd_err
module ingress_port_queue
   import switch_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   ingress_port_queue_if.slave      bus,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         drop_cnt,
   output logic [CNT_W-1:0]         ovf_cnt,
   output logic                     rd_err,
   input  logic                     clr_stats
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] level_q;
   logic [CNT_W-1:0] drop_q;
   logic [CNT_W-1:0] ovf_q;
   logic             rd_err_q;

   logic      full;
   logic      is_empty;
   logic      accept;
   logic      store;
   logic      drop;
   logic      pop;
   pkt_byte_t head;

   // level alone decides full/empty; the pointers wrap and carry no extra bit
   assign full     = (level_q == FULL_LVL);
   assign is_empty = (level_q == '0);

   // No write-through when full, even if the scheduler pops this cycle
   assign bus.in_ready = rst_n && !full;

   assign accept = bus.in_valid && bus.in_ready;
   assign store  = accept && is_valid_dest(bus.in_data);
   assign drop   = accept && !is_valid_dest(bus.in_data);
   assign pop    = bus.rdreq && !is_empty;

   ingress_queue_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (store),
      .wr_addr (wr_ptr),
      .wr_data (bus.in_data),
      .rd_addr (rd_ptr),
      .rd_data (head)
   );

   // Storage is not reset, so the head is masked to 0 while empty
   assign bus.data  = is_empty ? '0 : head;
   assign bus.empty = is_empty;

   assign level    = level_q;
   assign drop_cnt = drop_q;
   assign ovf_cnt  = ovf_q;
   assign rd_err   = rd_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level_q  <= '0;
         drop_q   <= '0;
         ovf_q    <= '0;
         rd_err_q <= 1'b0;
      end else begin
         if (store) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end

         // A write into an empty queue with rdreq lands here as +1 because pop is 0
         if (store && !pop) begin
            level_q <= level_q + LVL_W'(1);
         end else if (pop && !store) begin
            level_q <= level_q - LVL_W'(1);
         end

         // Clear wins over any increment in the same cycle
         if (clr_stats) begin
            drop_q   <= '0;
            ovf_q    <= '0;
            rd_err_q <= 1'b0;
         end else begin
            if (drop && (drop_q != '1)) begin
               drop_q <= drop_q + CNT_W'(1);
            end
            if (bus.in_valid && full && (ovf_q != '1)) begin
               ovf_q <= ovf_q + CNT_W'(1);
            end
            if (bus.rdreq && is_empty) begin
               rd_err_q <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ingress_port_queue.sv
// tb/tb_ingress_port_queue.sv - self-checking bench for ingress_port_queue
module tb_ingress_port_queue;
   import switch_pkg::*;

   localparam int DEPTH = 8;
   localparam int CNT_W = 8;
   localparam int LVL_W = $clog2(DEPTH) + 1;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clr_stats = 1'b0;
   logic [LVL_W-1:0] level;
   logic [CNT_W-1:0] drop_cnt;
   logic [CNT_W-1:0] ovf_cnt;
   logic             rd_err;

   always #5 clk = ~clk;

   ingress_port_queue_if bus ();

   ingress_port_queue #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .level     (level),
      .drop_cnt  (drop_cnt),
      .ovf_cnt   (ovf_cnt),
      .rd_err    (rd_err),
      .clr_stats (clr_stats)
   );

   // Reference model: a plain byte queue plus counters
   byte unsigned m_q [$];
   int           m_drop;
   int           m_ovf;
   bit           m_err;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_drop = 0;
      m_ovf  = 0;
      m_err  = 1'b0;
   endtask

   task automatic check_all(input string tag);
      int unsigned exp_data;
      exp_data = (m_q.size() == 0) ? 0 : m_q[0];
      chk({tag, ".empty"},    32'(bus.empty),    32'(m_q.size() == 0));
      chk({tag, ".level"},    32'(level),        32'(m_q.size()));
      chk({tag, ".data"},     32'(bus.data),     exp_data);
      chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(rst_n && (m_q.size() < DEPTH)));
      chk({tag, ".drop_cnt"}, 32'(drop_cnt),     32'(m_drop));
      chk({tag, ".ovf_cnt"},  32'(ovf_cnt),      32'(m_ovf));
      chk({tag, ".rd_err"},   32'(rd_err),       32'(m_err));
   endtask

   task automatic drive(input bit v, input byte unsigned d, input bit r, input bit c);
      bus.in_valid = v;
      bus.in_data  = d;
      bus.rdreq    = r;
      clr_stats    = c;
   endtask

   // One clock with the currently driven inputs; the model applies the same edge
   task automatic step(input string tag);
      int  sz;
      bit  full;
      byte unsigned d;
      sz   = m_q.size();
      full = (sz == DEPTH);
      d    = bus.in_data;
      @(posedge clk);
      if (bus.rdreq && sz > 0) void'(m_q.pop_front());
      if (bus.in_valid && !full) begin
         if (d[1:0] != 2'b00) m_q.push_back(d);
         else if (m_drop < CNT_MAX) m_drop++;
      end
      if (bus.in_valid && full && m_ovf < CNT_MAX) m_ovf++;
      if (bus.rdreq && sz == 0) m_err = 1'b1;
      if (clr_stats) begin
         m_drop = 0;
         m_ovf  = 0;
         m_err  = 1'b0;
      end
      #1;
      check_all(tag);
   endtask

   initial begin
      drive(0, 8'h00, 0, 0);
      model_reset();
      #2;
      check_all("in_reset");
      chk("in_reset.in_ready_low", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_all("post_reset");
      chk("post_reset.in_ready_high", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Two writes then a single pop
      drive(1, 8'h41, 0, 0); step("wr41");
      chk("wr41.head", 32'(bus.data), 32'h41);
      drive(1, 8'h82, 0, 0); step("wr82");
      chk("wr82.level", 32'(level), 32'd2);
      drive(0, 8'h00, 1, 0); step("pop1");
      chk("pop1.head", 32'(bus.data), 32'h82);
      chk("pop1.level", 32'(level), 32'd1);
      step("pop2");

      // Invalid destination is accepted but discarded
      drive(1, 8'h40, 0, 0);
      chk("drop.in_ready", 32'(bus.in_ready), 32'd1);
      step("drop");
      chk("drop.cnt", 32'(drop_cnt), 32'd1);
      chk("drop.empty", 32'(bus.empty), 32'd1);

      // Fill to DEPTH then hold in_valid while full
      for (int i = 1; i <= DEPTH; i++) begin
         drive(1, byte'((i & 8'hFC) | 8'h01), 0, 0);
         step("fill");
      end
      drive(1, 8'hA5, 0, 0);
      for (int i = 0; i < 3; i++) step("ovf");
      chk("full.in_ready", 32'(bus.in_ready), 32'd0);
      chk("full.level", 32'(level), 32'd8);
      chk("full.ovf_cnt", 32'(ovf_cnt), 32'd3);
      drive(1, 8'hA5, 1, 0); step("full_pop");
      chk("full_pop.level", 32'(level), 32'd7);

      // Drain, then pop while empty
      drive(0, 8'h00, 1, 0);
      for (int i = 0; i < 7; i++) step("drain");
      step("rd_empty");
      chk("rd_empty.rd_err", 32'(rd_err), 32'd1);
      chk("rd_empty.level", 32'(level), 32'd0);
      drive(1, 8'h33, 1, 0); step("wr_rd_empty");
      chk("wr_rd_empty.level", 32'(level), 32'd1);
      chk("wr_rd_empty.head", 32'(bus.data), 32'h33);
      drive(1, 8'h00, 0, 1); step("clr");
      chk("clr.drop", 32'(drop_cnt), 32'd0);
      chk("clr.ovf", 32'(ovf_cnt), 32'd0);
      chk("clr.rd_err", 32'(rd_err), 32'd0);
      drive(0, 8'h00, 1, 0); step("clr_drain");

      // Asynchronous reset mid-stream, no clock edge involved
      for (int i = 0; i < 5; i++) begin
         drive(1, byte'(8'h10 + i * 4 + 2), 0, 0);
         step("load5");
      end
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      chk("async_rst.level", 32'(level), 32'd0);
      drive(0, 8'h00, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      drive(1, 8'h55, 0, 0); step("after_rst");
      chk("after_rst.head", 32'(bus.data), 32'h55);
      drive(0, 8'h00, 1, 0); step("after_rst_pop");

      // Randomized traffic in phases biased toward filling or draining
      for (int ph = 0; ph < 8; ph++) begin
         int pv;
         int pr;
         pv = ph[0] ? 85 : 40;
         pr = ph[0] ? 25 : 70;
         for (int i = 0; i < 60; i++) begin
            drive(($urandom_range(99) < pv), byte'($urandom_range(255)),
                  ($urandom_range(99) < pr), ($urandom_range(99) < 4));
            step("rand");
         end
      end

      // Counter saturation
      drive(0, 8'h00, 0, 1); step("sat_clr");
      drive(0, 8'h00, 1, 0);
      for (int i = 0; i < DEPTH; i++) step("sat_drain");
      drive(1, 8'hFC, 0, 0);
      for (int i = 0; i < CNT_MAX + 4; i++) step("drop_sat");
      chk("drop_sat.cnt", 32'(drop_cnt), 32'(CNT_MAX));
      drive(1, 8'h07, 0, 0);
      for (int i = 0; i < DEPTH + CNT_MAX + 4; i++) step("ovf_sat");
      chk("ovf_sat.cnt", 32'(ovf_cnt), 32'(CNT_MAX));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL timeout: bench did not complete");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1);
   end

endmodule
